svo_tmds_dec: RTL and testbench

- Receive-side counterpart of the TMDS encoder: one instance per HDMI/DVI channel, in the pixel clock domain.
- Consumes raw 10-bit words from an external IDES10 deserializer and aligns the word boundary by pulsing the deserializer's bitslip input until control tokens appear.
- Once aligned, decodes each word into 8-bit pixel data, DE and the 2-bit control field.

---
 rtl/svo_tmds_dec_if.sv | 21 ++
 rtl/svo_tmds_dec.sv | 147 ++++++++++++++
 tb/tb_svo_tmds_dec.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/svo_tmds_dec_if.sv
// TMDS receive channel bundle: raw deserializer word in, alignment control and
// decoded pixel/control fields out.
interface svo_tmds_dec_if;
   logic [9:0] din;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_count;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] dout;

   modport master (
      output din,
      input  bitslip, locked, slip_count, de, ctrl, dout
   );

   modport slave (
      input  din,
      output bitslip, locked, slip_count, de, ctrl, dout
   );
endinterface

// File: rtl/svo_tmds_dec.sv
// TMDS channel decoder: finds the 10-bit word boundary by slipping the
// deserializer until control-token runs appear, then decodes pixels/controls.
module svo_tmds_dec #(
   parameter int LOCK_COUNT    = 16,
   parameter int SEARCH_WINDOW = 2048,
   parameter int SLIP_WAIT     = 8
) (
   input  logic          clk,
   input  logic          resetn,
   svo_tmds_dec_if.slave bus
);

   localparam int TOK_W  = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W  = $clog2(SEARCH_WINDOW);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

   localparam logic [TOK_W-1:0]  TOK_FULL  = TOK_W'(LOCK_COUNT);
   localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_COUNT - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_WAIT,
      ST_LOCKED
   } state_t;

   state_t            state_q, state_d;
   logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [3:0]        slip_count_q, slip_count_d;
   logic              de_q, de_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [7:0]        dout_q, dout_d;

   logic              is_tok;
   logic [1:0]        tok_ctrl;
   logic              hunting;
   logic              run_done;

   // Inverse of the transition-minimising stage of the TMDS encoder.
   function automatic logic [7:0] tmds_decode(input logic [9:0] w);
      logic [7:0] t;
      logic [7:0] r;
      t    = w[9] ? ~w[7:0] : w[7:0];
      r[0] = t[0];
      for (int i = 1; i < 8; i++) begin
         r[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      end
      return r;
   endfunction

   always_comb begin
      is_tok   = 1'b1;
      tok_ctrl = 2'b00;
      case (bus.din)
         10'b1101010100: tok_ctrl = 2'b00;
         10'b0010101011: tok_ctrl = 2'b01;
         10'b0101010100: tok_ctrl = 2'b10;
         10'b1010101011: tok_ctrl = 2'b11;
         default:        is_tok   = 1'b0;
      endcase
   end

   always_comb begin
      hunting  = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
      // A saturated run keeps refreshing the window for as long as tokens last.
      run_done = hunting && is_tok && (tok_cnt_q >= TOK_LAST);

      tok_cnt_d = '0;
      if (hunting && is_tok) begin
         tok_cnt_d = (tok_cnt_q == TOK_FULL) ? TOK_FULL : tok_cnt_q + 1'b1;
      end

      state_d = state_q;
      case (state_q)
         ST_SEARCH: begin
            if (run_done)                  state_d = ST_LOCKED;
            else if (win_cnt_q == WIN_LAST) state_d = ST_SLIP;
         end
         ST_SLIP:   state_d = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST)   state_d = ST_SEARCH;
         end
         ST_LOCKED: begin
            if (!run_done && (win_cnt_q == WIN_LAST)) state_d = ST_SLIP;
         end
         default:   state_d = ST_SEARCH;
      endcase

      win_cnt_d = win_cnt_q + 1'b1;
      if (!hunting || run_done || (state_d != state_q)) begin
         win_cnt_d = '0;
      end

      wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;

      slip_count_d = slip_count_q;
      if (state_d == ST_SLIP) begin
         slip_count_d = (slip_count_q == 4'd9) ? 4'd0 : slip_count_q + 4'd1;
      end

      de_d   = 1'b0;
      ctrl_d = ctrl_q;
      dout_d = 8'h00;
      if (state_q == ST_LOCKED) begin
         if (is_tok) begin
            ctrl_d = tok_ctrl;
         end else begin
            de_d   = 1'b1;
            dout_d = tmds_decode(bus.din);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_SEARCH;
         tok_cnt_q    <= '0;
         win_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         slip_count_q <= '0;
         de_q         <= 1'b0;
         ctrl_q       <= 2'b00;
         dout_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         tok_cnt_q    <= tok_cnt_d;
         win_cnt_q    <= win_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         slip_count_q <= slip_count_d;
         de_q         <= de_d;
         ctrl_q       <= ctrl_d;
         dout_q       <= dout_d;
      end
   end

   assign bus.bitslip    = (state_q == ST_SLIP);
   assign bus.locked     = (state_q == ST_LOCKED);
   assign bus.slip_count = slip_count_q;
   assign bus.de         = de_q;
   assign bus.ctrl       = ctrl_q;
   assign bus.dout       = dout_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Directed bench for svo_tmds_dec: table of locked decode vectors plus
// hand-written alignment, lock-loss, tie-break and async-reset sequences.
module tb_svo_tmds_dec;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam int SW_A = 64;
   localparam int SLIP_WAIT = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn_a;
   logic rstn_b;

   svo_tmds_dec_if bus_a();
   svo_tmds_dec_if bus_b();

   svo_tmds_dec #(.LOCK_COUNT(16), .SEARCH_WINDOW(SW_A), .SLIP_WAIT(SLIP_WAIT)) dut_a (
      .clk(clk), .resetn(rstn_a), .bus(bus_a.slave)
   );

   svo_tmds_dec #(.LOCK_COUNT(16), .SEARCH_WINDOW(16), .SLIP_WAIT(SLIP_WAIT)) dut_b (
      .clk(clk), .resetn(rstn_b), .bus(bus_b.slave)
   );

   typedef struct {
      logic [9:0] din;
      logic       locked;
      logic       de;
      logic [1:0] ctrl;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[$];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [9:0] d, input logic l, input logic e,
                          input logic [1:0] c, input logic [7:0] o);
      vec_t v;
      v.din = d; v.locked = l; v.de = e; v.ctrl = c; v.dout = o;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
      logic [9:0] r;
      r = w;
      for (int k = 0; k < n; k++) r = {r[8:0], r[9]};
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int off, pulses, last, min_gap;
      logic prev_bs, dbl_bs;

      rstn_a = 1'b0;
      rstn_b = 1'b0;
      bus_a.din = '0;
      bus_b.din = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bitslip", bus_a.bitslip, 0);
      chk("rst_locked", bus_a.locked, 0);
      chk("rst_slip_count", bus_a.slip_count, 0);
      chk("rst_de", bus_a.de, 0);
      chk("rst_ctrl", bus_a.ctrl, 0);
      chk("rst_dout", bus_a.dout, 0);
      rstn_a = 1'b1;

      // Aligned stream, then control and data decode while locked.
      for (int i = 0; i < 20; i++) add_vec(T00, (i >= 15), 1'b0, 2'd0, 8'h00);
      add_vec(10'b0100000000, 1'b1, 1'b1, 2'd0, 8'h00);
      add_vec(T01,            1'b1, 1'b0, 2'd1, 8'h00);
      add_vec(T10,            1'b1, 1'b0, 2'd2, 8'h00);
      add_vec(T11,            1'b1, 1'b0, 2'd3, 8'h00);
      add_vec(10'b1000000000, 1'b1, 1'b1, 2'd3, 8'hFF);
      add_vec(10'b0111111111, 1'b1, 1'b1, 2'd3, 8'h01);
      add_vec(10'b1100110011, 1'b1, 1'b1, 2'd3, 8'h54);
      add_vec(10'b0000001111, 1'b1, 1'b1, 2'd3, 8'hEF);
      add_vec(T00,            1'b1, 1'b0, 2'd0, 8'h00);

      foreach (vecs[i]) begin
         bus_a.din = vecs[i].din;
         step();
         chk($sformatf("vec%0d_locked", i), bus_a.locked, vecs[i].locked);
         chk($sformatf("vec%0d_de", i), bus_a.de, vecs[i].de);
         chk($sformatf("vec%0d_ctrl", i), bus_a.ctrl, vecs[i].ctrl);
         chk($sformatf("vec%0d_dout", i), bus_a.dout, vecs[i].dout);
         chk($sformatf("vec%0d_bitslip", i), bus_a.bitslip, 0);
      end

      // Lock loss: refresh with a full run, then a token-free window.
      for (int i = 0; i < 16; i++) begin
         bus_a.din = T11;
         step();
      end
      chk("refresh_ctrl", bus_a.ctrl, 3);
      for (int j = 0; j < SW_A; j++) begin
         bus_a.din = 10'b0111111111;
         step();
         chk($sformatf("loss%0d_locked", j), bus_a.locked, (j < SW_A - 1));
         chk($sformatf("loss%0d_bitslip", j), bus_a.bitslip, (j == SW_A - 1));
         chk($sformatf("loss%0d_de", j), bus_a.de, 1);
         chk($sformatf("loss%0d_dout", j), bus_a.dout, 8'h01);
      end
      step();
      chk("after_slip_bitslip", bus_a.bitslip, 0);
      chk("after_slip_count", bus_a.slip_count, 1);
      chk("after_slip_locked", bus_a.locked, 0);
      chk("after_slip_ctrl", bus_a.ctrl, 3);

      // Async reset in the middle of WAIT, between clock edges.
      repeat (3) step();
      #2;
      rstn_a = 1'b0;
      #1;
      chk("arst_bitslip", bus_a.bitslip, 0);
      chk("arst_locked", bus_a.locked, 0);
      chk("arst_slip_count", bus_a.slip_count, 0);
      chk("arst_de", bus_a.de, 0);
      chk("arst_ctrl", bus_a.ctrl, 0);
      chk("arst_dout", bus_a.dout, 0);
      @(posedge clk);
      #1;
      rstn_a = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus_a.din = T00;
         step();
         chk($sformatf("restart%0d_locked", i), bus_a.locked, (i == 15));
         chk($sformatf("restart%0d_bitslip", i), bus_a.bitslip, 0);
      end

      // Misaligned stream; the model rotates back one bit per bitslip pulse.
      rstn_a = 1'b0;
      #2;
      rstn_a = 1'b1;
      off = 3;
      pulses = 0;
      last = -1;
      min_gap = 1000;
      prev_bs = 1'b0;
      dbl_bs = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus_a.din = rotl(T00, off);
         step();
         if (bus_a.bitslip) begin
            pulses++;
            if (prev_bs) dbl_bs = 1'b1;
            if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
            last = cyc;
            if (off > 0) off--;
         end
         prev_bs = bus_a.bitslip;
         if (bus_a.locked) break;
      end
      chk("align_locked", bus_a.locked, 1);
      chk("align_pulses", pulses, 3);
      chk("align_slip_count", bus_a.slip_count, 3);
      chk("align_gap_ok", (min_gap >= SLIP_WAIT + 2), 1);
      chk("align_no_double", dbl_bs, 0);

      // Window expiry and run completion in the same cycle.
      @(posedge clk);
      #1;
      rstn_b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus_b.din = T00;
         step();
         chk($sformatf("tie%0d_locked", i), bus_b.locked, (i >= 15));
         chk($sformatf("tie%0d_bitslip", i), bus_b.bitslip, 0);
      end
      chk("tie_slip_count", bus_b.slip_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
